// File: rtl/stream_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_buffer
// Description : Fully registered valid/ready stream FIFO of DEPTH words.
//               in_ready, out_valid, out_data and level all come straight
//               from flops, so no combinational path crosses the buffer in
//               either direction. out_data is a prefetch register that always
//               shows the oldest stored word.
// Options     : define STREAM_FIFO_FLUSH_EN to add the synchronous 'flush'
//               input (discards all contents, keeps out_data).
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEVEL_WIDTH-1:0] level
`ifdef STREAM_FIFO_FLUSH_EN
    ,
    input  logic                   flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [LEVEL_WIDTH-1:0] c_level_zero = '0;
    localparam logic [LEVEL_WIDTH-1:0] c_level_one  = LEVEL_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] c_level_full = LEVEL_WIDTH'(DEPTH);
    localparam logic [PTR_W-1:0]       c_ptr_one    = PTR_W'(1);

    // Storage and registered state
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;

    // Combinational decode
    logic                   w_flush;
    logic                   w_push;
    logic                   w_pop;
    logic [LEVEL_WIDTH-1:0] w_level_nxt;
    logic [PTR_W-1:0]       w_rd_ptr_inc;
    logic                   w_load_direct;
    logic                   w_load_mem;

`ifdef STREAM_FIFO_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A flush cancels both handshakes of its cycle, so the pushed word is
    // dropped and nothing is counted as popped.
    assign w_push = in_valid & r_in_ready & ~w_flush;
    assign w_pop  = r_out_valid & out_ready & ~w_flush;

    // Pointers are power-of-two wide, so the increment wraps DEPTH-1 -> 0.
    assign w_rd_ptr_inc = r_rd_ptr + c_ptr_one;

    // The incoming word becomes the head when the buffer is empty, or when
    // the only stored word leaves in the same cycle.
    assign w_load_direct = w_push &
                           ((r_level == c_level_zero) |
                            ((r_level == c_level_one) & w_pop));

    // Any other pop with a word behind the head promotes that word. With
    // level >= 2 the successor is already in the array, even if a new word
    // is being written this cycle.
    assign w_load_mem = w_pop & (r_level > c_level_one);

    // Next fill level from the push/pop pair, flush overriding both
    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = c_level_zero;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_level_one;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_level_one;
        end
    end

    // Word array: every accepted word is written at the write pointer
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, level and the registered handshake flags
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= c_level_zero;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != c_level_full);
            r_out_valid <= (w_level_nxt != c_level_zero);
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_inc;
                end
            end
        end
    end

    // Head-of-queue prefetch register; holds its value when nothing loads
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_out_data <= '0;
        end else if (w_load_direct) begin
            r_out_data <= in_data;
        end else if (w_load_mem) begin
            r_out_data <= r_mem[w_rd_ptr_inc];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_level;

endmodule
`default_nettype wire
